// File: rtl/backprop_delta_pkg.sv
// Shared fixed-point constants and types for the backprop delta pipeline.
// Word format is signed Q(NBITS-FRAC).FRAC; the defaults here give Q8.8.
package backprop_delta_pkg;

  localparam int NBITS  = 16;
  localparam int FRAC   = 8;
  localparam int NELEM  = 4;
  localparam int ONE_FX = 1 << FRAC;
  localparam int MAX_FX = (1 << (NBITS - 1)) - 1;
  localparam int MIN_FX = -(1 << (NBITS - 1));

  typedef logic [7:0] idx_t;

endpackage

// File: rtl/backprop_delta_if.sv
// Element stream into the delta block and delta/bias-gradient stream out of it.
interface backprop_delta_if #(
  parameter int NBITS = backprop_delta_pkg::NBITS
);

  logic                         in_valid;
  logic                         in_ready;
  logic signed [NBITS-1:0]      in_err;
  logic signed [NBITS-1:0]      in_z;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [NBITS-1:0]      out_delta;
  backprop_delta_pkg::idx_t     out_idx;
  logic                         out_last;
  logic signed [NBITS-1:0]      out_bsum;

  modport slave (
    input  in_valid, in_err, in_z, out_ready,
    output in_ready, out_valid, out_delta, out_idx, out_last, out_bsum
  );

  modport master (
    output in_valid, in_err, in_z, out_ready,
    input  in_ready, out_valid, out_delta, out_idx, out_last, out_bsum
  );

endinterface

// File: rtl/backprop_delta_relu_deriv.sv
// ReLU derivative: 1.0 for z >= 0 (z = 0 included), 0 for negative z.
module backprop_delta_relu_deriv #(
  parameter int NBITS = backprop_delta_pkg::NBITS,
  parameter int FRAC  = backprop_delta_pkg::FRAC
) (
  input  logic signed [NBITS-1:0] z,
  output logic signed [NBITS-1:0] d
);

  localparam logic [NBITS-1:0] ONE = {{(NBITS-1){1'b0}}, 1'b1} << FRAC;

  assign d = z[NBITS-1] ? '0 : ONE;

endmodule

// File: rtl/backprop_delta.sv
// Two-stage delta = err * ReLU'(z) pipeline with element indexing and a
// saturating per-vector bias-gradient accumulator riding in the output stage.
module backprop_delta #(
  parameter int NBITS = backprop_delta_pkg::NBITS,
  parameter int FRAC  = backprop_delta_pkg::FRAC,
  parameter int NELEM = backprop_delta_pkg::NELEM
) (
  input  logic               clk,
  input  logic               rst_n,
  backprop_delta_if.slave    bus
);

  import backprop_delta_pkg::*;

  localparam int PW = 2 * NBITS;
  localparam logic signed [PW-1:0]    MAX_W    = {{(NBITS+1){1'b0}}, {(NBITS-1){1'b1}}};
  localparam logic signed [PW-1:0]    MIN_W    = {{(NBITS+1){1'b1}}, {(NBITS-1){1'b0}}};
  localparam logic signed [NBITS-1:0] MAX_N    = {1'b0, {(NBITS-1){1'b1}}};
  localparam logic signed [NBITS-1:0] MIN_N    = {1'b1, {(NBITS-1){1'b0}}};
  localparam idx_t                    LAST_IDX = idx_t'(NELEM - 1);

  // stage 1
  logic                    s1_valid_reg;
  logic signed [NBITS-1:0] s1_err_reg;
  logic signed [NBITS-1:0] s1_d_reg;
  idx_t                    s1_idx_reg;
  logic                    s1_last_reg;
  idx_t                    idx_reg;

  // stage 2 (output)
  logic                    out_valid_reg;
  logic signed [NBITS-1:0] out_delta_reg;
  idx_t                    out_idx_reg;
  logic                    out_last_reg;
  logic signed [NBITS-1:0] out_bsum_reg;

  logic signed [NBITS-1:0] d_next;
  logic signed [PW-1:0]    err_w;
  logic signed [PW-1:0]    d_w;
  logic signed [PW-1:0]    prod;
  logic signed [PW-1:0]    shifted;
  logic signed [NBITS-1:0] delta_next;
  logic signed [NBITS-1:0] bsum_base;
  logic signed [NBITS:0]   sum_wide;
  logic signed [NBITS-1:0] bsum_next;
  logic                    in_ready;
  logic                    in_fire;
  logic                    out_fire;
  logic                    s2_adv;
  logic                    s2_load;
  logic                    clear_acc;

  backprop_delta_relu_deriv #(
    .NBITS (NBITS),
    .FRAC  (FRAC)
  ) u_relu_deriv (
    .z (bus.in_z),
    .d (d_next)
  );

  assign out_fire  = out_valid_reg & bus.out_ready;
  assign s2_adv    = ~out_valid_reg | bus.out_ready;
  assign in_ready  = ~s1_valid_reg | s2_adv;
  assign in_fire   = bus.in_valid & in_ready;
  assign s2_load   = s1_valid_reg & s2_adv;
  assign clear_acc = out_fire & out_last_reg;

  always_comb begin
    err_w   = {{NBITS{s1_err_reg[NBITS-1]}}, s1_err_reg};
    d_w     = {{NBITS{s1_d_reg[NBITS-1]}}, s1_d_reg};
    prod    = err_w * d_w;
    shifted = prod >>> FRAC;
    if (shifted > MAX_W) begin
      delta_next = MAX_N;
    end else if (shifted < MIN_W) begin
      delta_next = MIN_N;
    end else begin
      delta_next = shifted[NBITS-1:0];
    end
  end

  // A vector's first element may enter stage 2 as the previous last leaves;
  // it must then start from zero rather than the departing total.
  always_comb begin
    bsum_base = clear_acc ? '0 : out_bsum_reg;
    sum_wide  = {bsum_base[NBITS-1], bsum_base} + {delta_next[NBITS-1], delta_next};
    if (sum_wide[NBITS] != sum_wide[NBITS-1]) begin
      bsum_next = sum_wide[NBITS] ? MIN_N : MAX_N;
    end else begin
      bsum_next = sum_wide[NBITS-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg <= '0;
    end else if (in_fire) begin
      idx_reg <= (idx_reg == LAST_IDX) ? '0 : idx_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_err_reg   <= '0;
      s1_d_reg     <= '0;
      s1_idx_reg   <= '0;
      s1_last_reg  <= 1'b0;
    end else if (in_ready) begin
      s1_valid_reg <= bus.in_valid;
      if (bus.in_valid) begin
        s1_err_reg  <= bus.in_err;
        s1_d_reg    <= d_next;
        s1_idx_reg  <= idx_reg;
        s1_last_reg <= (idx_reg == LAST_IDX);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_delta_reg <= '0;
      out_idx_reg   <= '0;
      out_last_reg  <= 1'b0;
      out_bsum_reg  <= '0;
    end else begin
      if (s2_adv) begin
        out_valid_reg <= s1_valid_reg;
      end
      if (s2_load) begin
        out_delta_reg <= delta_next;
        out_idx_reg   <= s1_idx_reg;
        out_last_reg  <= s1_last_reg;
        out_bsum_reg  <= bsum_next;
      end else if (clear_acc) begin
        out_bsum_reg  <= '0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_delta = out_delta_reg;
  assign bus.out_idx   = out_idx_reg;
  assign bus.out_last  = out_last_reg;
  assign bus.out_bsum  = out_bsum_reg;

endmodule

// File: tb/tb_backprop_delta.sv
// Directed bench for backprop_delta: reset, latency, ReLU cases, bias saturation,
// vector boundary, stall/hold behaviour and mid-vector reset.
module tb_backprop_delta;

  localparam int NB = 16;

  typedef logic [40:0] pk_t;
  typedef struct {
    logic [15:0] err;
    logic [15:0] z;
    pk_t         exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  backprop_delta_if #(.NBITS(NB)) bus();

  backprop_delta #(
    .NBITS (NB),
    .FRAC  (8),
    .NELEM (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   failures = 0;
  vec_t q[$];
  bit   saw_block;

  function automatic pk_t pk(logic [15:0] d, logic [7:0] i, logic l, logic [15:0] b);
    return {d, i, l, b};
  endfunction

  function automatic pk_t obs_pk();
    return {bus.out_delta, bus.out_idx, bus.out_last, bus.out_bsum};
  endfunction

  task automatic chk(input string tag, input pk_t o, input pk_t e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic add(input logic [15:0] err, input logic [15:0] z, input logic [15:0] d,
                     input logic [7:0] i, input logic l, input logic [15:0] b);
    vec_t v;
    v.err = err;
    v.z   = z;
    v.exp = pk(d, i, l, b);
    q.push_back(v);
  endtask

  // Entered and left on a falling edge; inputs change only on falling edges.
  task automatic run_stream(input string tag, input bit toggle);
    int  n;
    int  sent;
    int  got;
    int  cyc;
    bit  stalled;
    pk_t held;
    n = q.size();
    sent = 0;
    got = 0;
    cyc = 0;
    stalled = 1'b0;
    held = '0;
    while (got < n && cyc < 200) begin
      if (stalled) chk({tag, "_hold"}, obs_pk(), held);
      bus.out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (sent < n) begin
        bus.in_valid = 1'b1;
        bus.in_err   = q[sent].err;
        bus.in_z     = q[sent].z;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (bus.out_valid && bus.out_ready) begin
        $display("txn %s #%0d idx=%0d delta=%h last=%0d bsum=%h", tag, got,
                 bus.out_idx, bus.out_delta, bus.out_last, bus.out_bsum);
        chk({tag, "_elem"}, obs_pk(), q[got].exp);
        got++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      if (bus.in_valid && !bus.in_ready) saw_block = 1'b1;
      stalled = bus.out_valid && !bus.out_ready;
      held = obs_pk();
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_count"}, 41'(got), 41'(n));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    q.delete();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_err    = '0;
    bus.in_z      = '0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_valid", 41'(bus.out_valid), 41'(0));
    chk("rst_out", obs_pk(), '0);
    chk("rst_in_ready", 41'(bus.in_ready), 41'(1));

    // single element: valid exactly two cycles after it is presented
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_err    = 16'h0180;
    bus.in_z      = 16'h0100;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("lat_early", 41'(bus.out_valid), 41'(0));
    @(negedge clk);
    chk("lat_valid", 41'(bus.out_valid), 41'(1));
    chk("lat_data", obs_pk(), pk(16'h0180, 8'd0, 1'b0, 16'h0180));
    $display("txn lat #0 idx=%0d delta=%h last=%0d bsum=%h",
             bus.out_idx, bus.out_delta, bus.out_last, bus.out_bsum);
    @(negedge clk);
    chk("lat_done", 41'(bus.out_valid), 41'(0));

    // rest of vector 0: negative z, zero z, full-scale err
    add(16'h0200, 16'hFF00, 16'h0000, 8'd1, 1'b0, 16'h0180);
    add(16'hFE00, 16'h0000, 16'hFE00, 8'd2, 1'b0, 16'hFF80);
    add(16'h7FFF, 16'h0001, 16'h7FFF, 8'd3, 1'b1, 16'h7F7F);
    run_stream("relu", 1'b0);

    // positive saturation, negative saturation, then a clean vector right behind
    add(16'h4000, 16'h0100, 16'h4000, 8'd0, 1'b0, 16'h4000);
    add(16'h4000, 16'h0100, 16'h4000, 8'd1, 1'b0, 16'h7FFF);
    add(16'h4000, 16'h0100, 16'h4000, 8'd2, 1'b0, 16'h7FFF);
    add(16'h4000, 16'h0100, 16'h4000, 8'd3, 1'b1, 16'h7FFF);
    add(16'h8000, 16'h0010, 16'h8000, 8'd0, 1'b0, 16'h8000);
    add(16'h8000, 16'h0010, 16'h8000, 8'd1, 1'b0, 16'h8000);
    add(16'h8000, 16'h0010, 16'h8000, 8'd2, 1'b0, 16'h8000);
    add(16'h8000, 16'h0010, 16'h8000, 8'd3, 1'b1, 16'h8000);
    add(16'h0010, 16'h0000, 16'h0010, 8'd0, 1'b0, 16'h0010);
    add(16'h0010, 16'h0000, 16'h0010, 8'd1, 1'b0, 16'h0020);
    add(16'h0010, 16'h0000, 16'h0010, 8'd2, 1'b0, 16'h0030);
    add(16'h0010, 16'h0000, 16'h0010, 8'd3, 1'b1, 16'h0040);
    run_stream("sat", 1'b0);

    // 8 back-to-back with out_ready toggling
    saw_block = 1'b0;
    add(16'h0100, 16'h0100, 16'h0100, 8'd0, 1'b0, 16'h0100);
    add(16'h0200, 16'h8000, 16'h0000, 8'd1, 1'b0, 16'h0100);
    add(16'hFF00, 16'h0000, 16'hFF00, 8'd2, 1'b0, 16'h0000);
    add(16'h0050, 16'h7FFF, 16'h0050, 8'd3, 1'b1, 16'h0050);
    add(16'h0300, 16'h0001, 16'h0300, 8'd0, 1'b0, 16'h0300);
    add(16'hFD00, 16'h0001, 16'hFD00, 8'd1, 1'b0, 16'h0000);
    add(16'h1234, 16'hFFFF, 16'h0000, 8'd2, 1'b0, 16'h0000);
    add(16'h0007, 16'h0020, 16'h0007, 8'd3, 1'b1, 16'h0007);
    run_stream("toggle", 1'b1);
    chk("toggle_in_ready_drop", 41'(saw_block), 41'(1));

    // fill both stages under stall, then reset mid-vector
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_err    = 16'h0123;
    bus.in_z      = 16'h0100;
    @(negedge clk);
    bus.in_err    = 16'h0200;
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("full_data", obs_pk(), pk(16'h0123, 8'd0, 1'b0, 16'h0123));
    chk("full_in_ready", 41'(bus.in_ready), 41'(0));
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 41'(bus.out_valid), 41'(0));
    chk("arst_out", obs_pk(), '0);
    chk("arst_in_ready", 41'(bus.in_ready), 41'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    add(16'h0040, 16'h0100, 16'h0040, 8'd0, 1'b0, 16'h0040);
    add(16'h0010, 16'h0100, 16'h0010, 8'd1, 1'b0, 16'h0050);
    run_stream("post_rst", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
